// File: rtl/acc_pkg.sv
// Shared defaults and FSM encoding for the block-adder controller slice.
package acc_pkg;
  localparam int LANES      = 9;
  localparam int DW         = 32;
  localparam int CW         = 16;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/block_pair_fifo.sv
// Synchronous FIFO holding one branch's partial-sum words; head is visible
// combinationally so the adder input can be driven straight from it.
module block_pair_fifo #(
  parameter int W     = acc_pkg::LANES * acc_pkg::DW,
  parameter int DEPTH = acc_pkg::FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wp, rp;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rd_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr_en && !full)  wp <= wp + {{AW{1'b0}}, 1'b1};
      if (rd_en && !empty) rp <= rp + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wp[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/block_adder_ctrl.sv
// Pairs branch A/B partial-sum words, fires the registered block adder and
// tracks its output slot. Optional BLOCK_ADDER_CTRL_PERF_EN adds stall_cnt.
module block_adder_ctrl #(
  parameter int LANES      = acc_pkg::LANES,
  parameter int DW         = acc_pkg::DW,
  parameter int DWO        = LANES * DW,
  parameter int DWI        = 2 * DWO,
  parameter int CW         = acc_pkg::CW,
  parameter int FIFO_DEPTH = acc_pkg::FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [CW-1:0]  num_pix,
  input  logic           a_valid,
  output logic           a_ready,
  input  logic [DWO-1:0] a_data,
  input  logic           b_valid,
  output logic           b_ready,
  input  logic [DWO-1:0] b_data,
  output logic           add_en,
  output logic [DWI-1:0] add_din,
  output logic           o_valid,
  input  logic           o_ready,
  output logic           busy,
  output logic           done
`ifdef BLOCK_ADDER_CTRL_PERF_EN
  , output logic [31:0]  stall_cnt
`endif
);
  import acc_pkg::*;

  state_e         state;
  logic [CW-1:0]  num_pix_r, a_cnt, b_cnt, iss_cnt, out_cnt;
  logic           a_full, a_empty, b_full, b_empty;
  logic [DWO-1:0] a_head, b_head;
  logic           run, start_acc, a_xfer, b_xfer, fire, consume;

  assign run       = (state == RUN);
  assign start_acc = start && (state == IDLE);

  // Each branch stops accepting once it has delivered the whole tile.
  assign a_ready = run && !a_full && (a_cnt < num_pix_r);
  assign b_ready = run && !b_full && (b_cnt < num_pix_r);
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;

  assign consume = o_valid && o_ready;
  assign fire    = run && !a_empty && !b_empty && (!o_valid || o_ready);
  assign add_en  = fire;
  assign add_din = {b_head, a_head};

  block_pair_fifo #(.W(DWO), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .clr(start_acc),
    .wr_en(a_xfer), .wr_data(a_data), .rd_en(fire),
    .rd_data(a_head), .full(a_full), .empty(a_empty)
  );

  block_pair_fifo #(.W(DWO), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .clr(start_acc),
    .wr_en(b_xfer), .wr_data(b_data), .rd_en(fire),
    .rd_data(b_head), .full(b_full), .empty(b_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      num_pix_r <= '0;
      a_cnt     <= '0;
      b_cnt     <= '0;
      iss_cnt   <= '0;
      out_cnt   <= '0;
      o_valid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // A same-cycle consume and fire keeps the slot occupied.
      if (fire)         o_valid <= 1'b1;
      else if (consume) o_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            num_pix_r <= num_pix;
            a_cnt     <= '0;
            b_cnt     <= '0;
            iss_cnt   <= '0;
            out_cnt   <= '0;
            busy      <= 1'b1;
            if (num_pix == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (a_xfer)  a_cnt   <= a_cnt + CW'(1);
          if (b_xfer)  b_cnt   <= b_cnt + CW'(1);
          if (fire)    iss_cnt <= iss_cnt + CW'(1);
          if (consume) out_cnt <= out_cnt + CW'(1);
          if (out_cnt == num_pix_r) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BLOCK_ADDER_CTRL_PERF_EN
  // Branch skew: one side has data waiting while the other has none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (start_acc)
      stall_cnt <= '0;
    else if (run && (a_empty != b_empty) && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_block_adder_ctrl.sv
// Directed bench for block_adder_ctrl with a behavioural 9-lane registered adder.
module tb_block_adder_ctrl;
  localparam int LANES = 9;
  localparam int DWO   = 288;
  localparam int DWI   = 576;
  localparam int CW    = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [CW-1:0]  num_pix;
  logic           a_valid, a_ready, b_valid, b_ready;
  logic [DWO-1:0] a_data, b_data;
  logic           add_en;
  logic [DWI-1:0] add_din;
  logic           o_valid, o_ready, busy, done;
`ifdef BLOCK_ADDER_CTRL_PERF_EN
  logic [31:0]    stall_cnt;
`endif
  logic [DWO-1:0] add_dout;

  block_adder_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pix(num_pix),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .add_en(add_en), .add_din(add_din),
    .o_valid(o_valid), .o_ready(o_ready), .busy(busy), .done(done)
`ifdef BLOCK_ADDER_CTRL_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Registered block adder: lane sums wrap mod 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) add_dout <= '0;
    else if (add_en)
      for (int l = 0; l < LANES; l++)
        add_dout[l*32 +: 32] <= add_din[l*32 +: 32] + add_din[DWO + l*32 +: 32];
  end

  function automatic logic [DWO-1:0] mkw(input logic [31:0] v);
    logic [DWO-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*32 +: 32] = v + 32'(l);
    return w;
  endfunction

  function automatic logic [DWO-1:0] expsum(input logic [31:0] va, input logic [31:0] vb);
    logic [DWO-1:0] w;
    for (int l = 0; l < LANES; l++) w[l*32 +: 32] = (va + 32'(l)) + (vb + 32'(l));
    return w;
  endfunction

  int nchk = 0, errs = 0;
  int cyc = 0, s0 = 0;
  int a_dly = 0, b_dly = 0;
  logic [31:0]    a_q[$], b_q[$];
  logic [DWO-1:0] got_q[$], exp_q[$];
  int n_done, n_fire, n_rdy, n_ov, first_hs, first_ov, first_en;

  task automatic chk(input string tag, input logic [DWO-1:0] got, input logic [DWO-1:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin : drv_a
    logic hs;
    hs = a_valid && a_ready;
    #2;
    if (hs && a_q.size() > 0) void'(a_q.pop_front());
    if (a_dly > 0) a_dly--;
    a_valid = (a_dly == 0) && (a_q.size() > 0);
    a_data  = a_valid ? mkw(a_q[0]) : '0;
  end

  always @(posedge clk) begin : drv_b
    logic hs;
    hs = b_valid && b_ready;
    #2;
    if (hs && b_q.size() > 0) void'(b_q.pop_front());
    if (b_dly > 0) b_dly--;
    b_valid = (b_dly == 0) && (b_q.size() > 0);
    b_data  = b_valid ? mkw(b_q[0]) : '0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && o_ready) got_q.push_back(add_dout);
      if (done)               n_done++;
      if (add_en)             n_fire++;
      if (a_ready || b_ready) n_rdy++;
      if (o_valid)            n_ov++;
      if (first_hs < 0 && a_valid && a_ready && b_valid && b_ready) first_hs = cyc;
      if (first_ov < 0 && o_valid) first_ov = cyc;
      if (first_en < 0 && add_en)  first_en = cyc;
    end
  end

  task automatic start_tile(input int n, input int nw, input logic [31:0] ba, input logic [31:0] sa,
                            input logic [31:0] bb, input logic [31:0] sb, input int da, input int db);
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete(); a_q.delete(); b_q.delete();
    n_done = 0; n_fire = 0; n_rdy = 0; n_ov = 0;
    first_hs = -1; first_ov = -1; first_en = -1;
    for (int i = 0; i < nw; i++) begin
      a_q.push_back(ba + sa * 32'(i));
      b_q.push_back(bb + sb * 32'(i));
      if (i < n) exp_q.push_back(expsum(ba + sa * 32'(i), bb + sb * 32'(i)));
    end
    a_dly = da; b_dly = db;
    num_pix = CW'(n); start = 1'b1; s0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic end_tile(input string t, input int n);
    int k;
    k = 0;
    while (!done && k < 300) begin @(negedge clk); k++; end
    chk({t, "_done"}, done, 1'b1);
    @(negedge clk);
    chk({t, "_idle"}, {busy, done}, 2'b00);
    chk({t, "_ndone"}, n_done, 1);
    chk({t, "_nout"}, got_q.size(), n);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({t, "_sum"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; num_pix = '0; o_ready = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {a_ready, b_ready, add_en, o_valid, busy, done}, 6'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rel", {a_ready, b_ready, add_en, o_valid, busy, done}, 6'b0);

    // Basic: A=1..4, B=10..40, lane0 sums 11,22,33,44
    o_ready = 1'b1;
    start_tile(4, 4, 32'd1, 32'd1, 32'd10, 32'd10, 0, 0);
    chk("basic_busy", busy, 1'b1);
    end_tile("basic", 4);
    chk("basic_l0", got_q[3][31:0], 32'd44);
    chk("basic_lat", first_ov - first_hs, 2);
    chk("basic_ovcyc", n_ov, 4);
    chk("basic_fire", n_fire, 4);

    // Skew: A ready 2 words, B first accepted 3 cycles later
    start_tile(4, 4, 32'd5, 32'd1, 32'd50, 32'd10, 0, 5);
    @(negedge clk);
    @(negedge clk); chk("skew_en2", add_en, 1'b0);
    @(negedge clk); chk("skew_en3", add_en, 1'b0); chk("skew_full3", a_ready, 1'b0);
    @(negedge clk); chk("skew_en4", add_en, 1'b0); chk("skew_full4", a_ready, 1'b0);
    end_tile("skew", 4);
    chk("skew_first_en", first_en - s0, 5);
    chk("skew_fire", n_fire, 4);
`ifdef BLOCK_ADDER_CTRL_PERF_EN
    chk("skew_stall", stall_cnt, 32'd3);
`endif

    // Backpressure: hold o_ready low for 5 cycles after first o_valid
    o_ready = 1'b0;
    start_tile(3, 3, 32'd7, 32'd1, 32'd100, 32'd100, 0, 0);
    k = 0;
    while (!o_valid && k < 50) begin @(negedge clk); k++; end
    chk("bp_ov", o_valid, 1'b1);
    for (int j = 0; j < 5; j++) begin
      chk("bp_en", add_en, 1'b0);
      chk("bp_hold", add_dout, expsum(32'd7, 32'd100));
      if (j < 4) @(negedge clk);
    end
    @(posedge clk); #1 o_ready = 1'b1;
    end_tile("bp", 3);
    chk("bp_fire", n_fire, 3);

    // num_pix=0: done the cycle after start, no ready ever
    start_tile(0, 2, 32'd1, 32'd1, 32'd2, 32'd1, 0, 0);
    @(negedge clk);
    chk("zero_done", done, 1'b1);
    chk("zero_rdy", {a_ready, b_ready}, 2'b00);
    @(negedge clk);
    chk("zero_idle", {busy, done}, 2'b00);
    repeat (3) @(negedge clk);
    chk("zero_nrdy", n_rdy, 0);
    chk("zero_nout", got_q.size(), 0);

    // Lane wrap: 0xFFFFFFFF + 1 -> 0
    start_tile(1, 1, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 0, 0);
    end_tile("wrap", 1);
    chk("wrap_l0", got_q[0][31:0], 32'd0);
    chk("wrap_l1", got_q[0][63:32], 32'd2);

    // Second start mid-tile is ignored
    start_tile(2, 7, 32'd3, 32'd1, 32'd1000, 32'd1, 0, 0);
    #1 start = 1'b1; num_pix = CW'(7);
    @(posedge clk); #1 start = 1'b0;
    end_tile("ign", 2);
    repeat (4) @(negedge clk);
    chk("ign_nout", got_q.size(), 2);

    // Reset after first output, then a fresh tile
    start_tile(4, 4, 32'd1, 32'd1, 32'd10, 32'd10, 0, 0);
    k = 0;
    while (got_q.size() < 1 && k < 50) begin @(negedge clk); k++; end
    chk("mrst_first", got_q.size(), 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 chk("mrst_out", {a_ready, b_ready, add_en, o_valid, busy, done}, 6'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    start_tile(4, 4, 32'd2, 32'd1, 32'd20, 32'd10, 0, 0);
    end_tile("mrst", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1);
  end
endmodule
